// File: rtl/accel_byte_narrower.sv
`default_nettype none
// ============================================================================
// Module      : accel_byte_narrower
// Description : Splits wide LSB-aligned memory lines into narrow output beats
//               for a streaming accelerator. Carries first/last/empty framing
//               through, counts frame bytes and supports a synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_byte_narrower #(
    parameter int IN_WIDTH       = 128,
    parameter int OUT_WIDTH      = 32,
    parameter int IN_EMPTY_BITS  = (IN_WIDTH / 8 > 1) ? $clog2(IN_WIDTH / 8) : 1,
    parameter int OUT_EMPTY_BITS = (OUT_WIDTH / 8 > 1) ? $clog2(OUT_WIDTH / 8) : 1,
    parameter int LEN_WIDTH      = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_WIDTH-1:0]       s_axis_tdata,
    input  logic [IN_EMPTY_BITS-1:0]  s_axis_tempty,
    input  logic                      s_axis_tfirst,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [OUT_WIDTH-1:0]      m_axis_tdata,
    output logic [OUT_EMPTY_BITS-1:0] m_axis_tempty,
    output logic                      m_axis_tfirst,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    input  logic                      flush,
    output logic [LEN_WIDTH-1:0]      frame_len,
    output logic                      frame_done
);

    localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
    localparam int IN_BYTES  = IN_WIDTH / 8;
    localparam int OUT_BYTES = OUT_WIDTH / 8;
    localparam int OUT_SHIFT = $clog2(OUT_BYTES);
    localparam int IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int NB_W      = $clog2(RATIO + 1);
    localparam int VB_W      = $clog2(IN_BYTES + 1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic [OUT_WIDTH-1:0]      data;
        logic [OUT_EMPTY_BITS-1:0] empty;
        logic                      first;
        logic                      last;
    } beat_t;

    // Builds beat 'idx' of a line holding 'vbytes' valid bytes spread over 'nbeats' beats.
    function automatic beat_t make_beat(
        input logic [IN_WIDTH-1:0] line,
        input logic [VB_W-1:0]     vbytes,
        input logic [NB_W-1:0]     nbeats,
        input logic                lfirst,
        input logic                llast,
        input logic [IDX_W-1:0]    idx
    );
        beat_t       b;
        logic        fin;
        logic [VB_W:0] span;
        fin     = (NB_W'(idx) == (nbeats - NB_W'(1)));
        span    = (VB_W + 1)'(nbeats) << OUT_SHIFT;
        b.data  = line[idx * OUT_WIDTH +: OUT_WIDTH];
        b.empty = (fin && llast) ? OUT_EMPTY_BITS'(span - {1'b0, vbytes}) : '0;
        b.first = lfirst && (idx == '0);
        b.last  = llast && fin;
        return b;
    endfunction

    state_t                 state_q;
    logic                   valid_q;
    beat_t                  beat_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IN_WIDTH-1:0]    line_q;
    logic [VB_W-1:0]        vbytes_q;
    logic [NB_W-1:0]        nbeats_q;
    logic                   lfirst_q;
    logic                   llast_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic [LEN_WIDTH-1:0]   frame_len_q;
    logic                   frame_done_q;

    logic                   out_hs;
    logic                   in_hs;
    logic                   final_beat;
    logic                   tready;
    logic [VB_W-1:0]        in_bytes_d;
    logic [VB_W:0]          in_round;
    logic [NB_W-1:0]        in_beats_d;
    beat_t                  first_beat_d;
    beat_t                  next_beat_d;
    logic [LEN_WIDTH-1:0]   beat_bytes;
    logic [LEN_WIDTH-1:0]   cnt_d;

    // Handshakes, line sizing and candidate next beats for the output register.
    always_comb begin
        out_hs       = valid_q && m_axis_tready;
        final_beat   = (NB_W'(idx_q) == (nbeats_q - NB_W'(1)));
        // Reset and flush both block acceptance; a line is taken only when the held one is leaving.
        tready       = rst_n && !flush && ((state_q == S_EMPTY) || (out_hs && final_beat));
        in_hs        = s_axis_tvalid && tready;
        in_bytes_d   = s_axis_tlast ? (VB_W'(IN_BYTES) - VB_W'(s_axis_tempty)) : VB_W'(IN_BYTES);
        in_round     = {1'b0, in_bytes_d} + (VB_W + 1)'(OUT_BYTES - 1);
        in_beats_d   = NB_W'(in_round >> OUT_SHIFT);
        first_beat_d = make_beat(s_axis_tdata, in_bytes_d, in_beats_d,
                                 s_axis_tfirst, s_axis_tlast, '0);
        next_beat_d  = make_beat(line_q, vbytes_q, nbeats_q, lfirst_q, llast_q,
                                 idx_q + IDX_W'(1));
        beat_bytes   = LEN_WIDTH'(OUT_BYTES) - LEN_WIDTH'(beat_q.empty);
        // A first beat restarts the count so an unterminated prior frame is dropped.
        cnt_d        = (beat_q.first ? '0 : cnt_q) + beat_bytes;
    end

    // Line holding register and beat sequencer; the output beat is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EMPTY;
            valid_q  <= 1'b0;
            beat_q   <= '0;
            idx_q    <= '0;
            line_q   <= '0;
            vbytes_q <= '0;
            nbeats_q <= '0;
            lfirst_q <= 1'b0;
            llast_q  <= 1'b0;
        end else if (flush) begin
            state_q <= S_EMPTY;
            valid_q <= 1'b0;
            beat_q  <= '0;
            idx_q   <= '0;
        end else if (in_hs) begin
            state_q  <= S_DRAIN;
            valid_q  <= 1'b1;
            beat_q   <= first_beat_d;
            idx_q    <= '0;
            line_q   <= s_axis_tdata;
            vbytes_q <= in_bytes_d;
            nbeats_q <= in_beats_d;
            lfirst_q <= s_axis_tfirst;
            llast_q  <= s_axis_tlast;
        end else if (out_hs) begin
            if (final_beat) begin
                state_q <= S_EMPTY;
                valid_q <= 1'b0;
                beat_q  <= '0;
                idx_q   <= '0;
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
                beat_q <= next_beat_d;
            end
        end
    end

    // Frame byte accounting: length is published on the last beat's handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            frame_len_q  <= '0;
            frame_done_q <= 1'b0;
        end else if (flush) begin
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (out_hs) begin
                if (beat_q.last) begin
                    frame_len_q  <= cnt_d;
                    cnt_q        <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    end

    assign s_axis_tready = tready;
    assign m_axis_tdata  = beat_q.data;
    assign m_axis_tempty = beat_q.empty;
    assign m_axis_tfirst = beat_q.first;
    assign m_axis_tlast  = beat_q.last;
    assign m_axis_tvalid = valid_q;
    assign frame_len     = frame_len_q;
    assign frame_done    = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_byte_narrower.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_byte_narrower
// Description : Self-checking bench for accel_byte_narrower (128 -> 32 bits).
//               A byte-level frame model predicts beats, ready and lengths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_byte_narrower;

    logic         clk;
    logic         rst_n;
    logic [127:0] s_tdata;
    logic [3:0]   s_tempty;
    logic         s_tfirst;
    logic         s_tlast;
    logic         s_tvalid;
    logic         s_tready;
    logic [31:0]  m_tdata;
    logic [1:0]   m_tempty;
    logic         m_tfirst;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic         flush;
    logic [13:0]  frame_len;
    logic         frame_done;

    accel_byte_narrower dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tempty (s_tempty),
        .s_axis_tfirst (s_tfirst),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tempty (m_tempty),
        .m_axis_tfirst (m_tfirst),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .flush         (flush),
        .frame_len     (frame_len),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  empty;
        logic        first;
        logic        last;
    } beat_t;

    beat_t       q[$];
    int          errors = 0;
    int          checks = 0;
    int          acc = 0;
    logic [13:0] exp_len = '0;
    logic        exp_done = 1'b0;
    int          cyc = 0;
    int          hs_total = 0;
    int          last_hs_cyc = 0;
    int          rdy_mode = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a line is a 16-byte array; its V valid bytes are cut into 4-byte beats.
    function automatic void push_line(input logic [127:0] d, input int te, input bit f, input bit l);
        logic [7:0] by[16];
        int v, nb;
        beat_t b;
        for (int i = 0; i < 16; i++) by[i] = d[8*i +: 8];
        v  = l ? 16 - te : 16;
        nb = (v + 3) / 4;
        for (int k = 0; k < nb; k++) begin
            b.data  = {by[4*k+3], by[4*k+2], by[4*k+1], by[4*k]};
            b.empty = (l && k == nb - 1) ? 2'(nb * 4 - v) : 2'd0;
            b.first = f && (k == 0);
            b.last  = l && (k == nb - 1);
            q.push_back(b);
        end
    endfunction

    // Output readiness pattern.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compare the DUT against the model, then advance the model with this cycle's handshakes.
    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (!rst_n) begin
            chk("rst_tvalid", {127'd0, m_tvalid}, 128'd0);
            chk("rst_tdata", {96'd0, m_tdata}, 128'd0);
            chk("rst_flags", {125'd0, m_tfirst, m_tlast, |m_tempty}, 128'd0);
            chk("rst_s_tready", {127'd0, s_tready}, 128'd0);
            chk("rst_frame_len", {114'd0, frame_len}, 128'd0);
            chk("rst_frame_done", {127'd0, frame_done}, 128'd0);
            q.delete();
            acc = 0;
            exp_len = '0;
            exp_done = 1'b0;
        end else begin
            chk("m_tvalid", {127'd0, m_tvalid}, {127'd0, q.size() != 0});
            if (q.size() != 0) begin
                chk("m_tdata", {96'd0, m_tdata}, {96'd0, q[0].data});
                chk("m_tempty", {126'd0, m_tempty}, {126'd0, q[0].empty});
                chk("m_tfirst", {127'd0, m_tfirst}, {127'd0, q[0].first});
                chk("m_tlast", {127'd0, m_tlast}, {127'd0, q[0].last});
            end
            chk("frame_done", {127'd0, frame_done}, {127'd0, exp_done});
            chk("frame_len", {114'd0, frame_len}, {114'd0, exp_len});
            chk("s_tready", {127'd0, s_tready},
                {127'd0, !flush && (q.size() == 0 || (m_tready && q.size() == 1))});
            exp_done = 1'b0;
            if (flush) begin
                q.delete();
                acc = 0;
            end else begin
                if (m_tvalid && m_tready && q.size() != 0) begin
                    b = q.pop_front();
                    hs_total++;
                    last_hs_cyc = cyc;
                    if (b.first) acc = 0;
                    acc += 4 - int'(b.empty);
                    if (b.last) begin
                        exp_len  = 14'(acc);
                        exp_done = 1'b1;
                        acc      = 0;
                    end
                end
                if (s_tvalid && s_tready) push_line(s_tdata, int'(s_tempty), s_tfirst, s_tlast);
            end
        end
    end

    // Presents one line and holds it until accepted; valid stays high for back-to-back use.
    task automatic send_line(input logic [127:0] d, input int te, input bit f, input bit l);
        bit hs;
        s_tdata  = d;
        s_tempty = 4'(te);
        s_tfirst = f;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            hs = s_tvalid && s_tready && !flush && rst_n;
            @(posedge clk);
            #1;
            if (hs) return;
        end
        chk("send_timeout", 128'd0, 128'd1);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", {127'd0, q.size() == 0}, 128'd1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] seq;
        int t4_start, hs0, nl;
        for (int i = 0; i < 16; i++) seq[8*i +: 8] = 8'(i);
        rst_n = 1'b0; flush = 1'b0; m_tready = 1'b1;
        s_tdata = '0; s_tempty = '0; s_tfirst = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Single line frame with incrementing bytes.
        send_line(seq, 0, 1, 1);
        idle(0);
        wait_drain();
        repeat (2) @(negedge clk);
        chk("t1_frame_len", {114'd0, frame_len}, 128'd16);

        // Three-line frame ending with 7 valid bytes.
        send_line(rnd128(), 0, 1, 0);
        send_line(rnd128(), 0, 0, 0);
        send_line(rnd128(), 9, 0, 1);
        idle(0);
        wait_drain();
        repeat (2) @(negedge clk);
        chk("t2_frame_len", {114'd0, frame_len}, 128'd39);

        // Alternating output readiness over two lines.
        rdy_mode = 1;
        send_line(rnd128(), 0, 1, 0);
        send_line(rnd128(), 0, 0, 1);
        idle(0);
        wait_drain();
        rdy_mode = 0;
        idle(3);

        // Eight back-to-back lines at full rate.
        hs0 = hs_total;
        send_line(rnd128(), 0, 1, 0);
        t4_start = cyc;
        for (int i = 1; i < 8; i++) send_line(rnd128(), 0, 0, i == 7);
        idle(0);
        wait_drain();
        chk("t4_beats", 128'(hs_total - hs0), 128'd32);
        chk("t4_last_cycle", 128'(last_hs_cyc), 128'(t4_start + 32));

        // Flush in the middle of the second line, then a fresh 16-byte frame.
        send_line(rnd128(), 0, 1, 0);
        send_line(rnd128(), 0, 0, 0);
        s_tdata = rnd128();
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("t5_flush_tvalid", {127'd0, m_tvalid}, 128'd0);
        idle(1);
        send_line(rnd128(), 0, 1, 1);
        idle(0);
        wait_drain();
        repeat (2) @(negedge clk);
        chk("t5_frame_len", {114'd0, frame_len}, 128'd16);

        // Reset pulse while a line is draining, then a normal frame.
        rdy_mode = 1;
        send_line(rnd128(), 0, 1, 1);
        idle(1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 0;
        send_line(rnd128(), 5, 1, 1);
        idle(0);
        wait_drain();
        repeat (2) @(negedge clk);
        chk("t6_frame_len", {114'd0, frame_len}, 128'd11);

        // Random frames, tempty and output backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                send_line(rnd128(), (l == nl - 1) ? $urandom_range(0, 15) : 0, l == 0, l == nl - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(0);
        wait_drain();
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
